// File: rtl/mem_slave_pkg.sv
// Shared definitions for the mem_slave main-memory model: FSM encoding,
// word offset of the byte address and latency counter width.
package mem_define;

    typedef enum logic [1:0] {
        S_M_IDLE = 2'd0,
        S_M_WAIT = 2'd1,
        S_M_ACK  = 2'd2,
        S_M_REL  = 2'd3
    } mem_state_t;

    localparam int WORD_OFF  = 2;
    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_slave_if.sv
// Single-word request bus between the cache refill/write-back port and
// the main-memory model.
interface mem_slave_if;

    logic        cs_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;

    modport master (
        output cs_i, we_i, addr_i, data_i,
        input  data_o, ack_o
    );

    modport slave (
        input  cs_i, we_i, addr_i, data_i,
        output data_o, ack_o
    );

endinterface

// File: rtl/mem_slave_array.sv
// Single-port synchronous RAM with write enable and a registered read port
// whose output register is cleared by reset (the array itself is not).
module mem_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Writes leave the read register untouched so data_o holds the last read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_slave.sv
// Word-addressed main-memory model with programmable access latency and an
// ack-low release gap. Define MEM_STATS_EN to add read/write commit counters.
module mem_slave
    import mem_define::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4,
    parameter int REL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    mem_slave_if.slave  bus
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] rd_cnt_o,
    output logic [15:0] wr_cnt_o
`endif
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] REL_INIT = LAT_CNT_W'(REL_CYCLES - 1);

    mem_state_t             state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   accept;
    logic                   commit;

    logic [ADDR_WIDTH-1:0]  idx_q;
    logic                   we_q;
    logic [31:0]            wdata_q;
    logic                   ack_q;
    logic [31:0]            rd_data;

    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_i[31:ADDR_WIDTH+WORD_OFF], bus.addr_i[WORD_OFF-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_M_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter is reused: latency countdown in WAIT, release gap in REL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_M_IDLE: begin
                if (bus.cs_i) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_INIT;
                    state_d = (LATENCY == 1) ? S_M_ACK : S_M_WAIT;
                end
            end
            S_M_WAIT: begin
                if (!bus.cs_i) begin
                    state_d = S_M_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_M_ACK;
                    end
                end
            end
            S_M_ACK: begin
                commit  = 1'b1;
                cnt_d   = REL_INIT;
                state_d = S_M_REL;
            end
            S_M_REL: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_M_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            idx_q   <= bus.addr_i[ADDR_WIDTH+WORD_OFF-1:WORD_OFF];
            we_q    <= bus.we_i;
            wdata_q <= bus.data_i;
        end
    end

    // Ack is registered on the commit edge, alongside the RAM read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= commit;
        end
    end

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_W     (32)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (commit),
        .we    (we_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

    assign bus.ack_o  = ack_q;
    assign bus.data_o = rd_data;

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (commit) begin
            if (we_q) begin
                wr_cnt_o <= wr_cnt_o + 16'd1;
            end else begin
                rd_cnt_o <= rd_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_slave.md
Name: mem_slave

Overview:
- Word-addressed main-memory model behind the cache management unit's refill/write-back port.
- Accepts single-word requests on cs/we/addr, waits a programmable latency, then performs the access and returns one ack pulse per word.
- Ack falls between words, so the requester's rising-edge ack detector sees each word exactly once.
- Requester holds cs high across a whole line burst and changes the address after each ack.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
- LATENCY, 4, cycles from acceptance to ack; legal 1..15.
- REL_CYCLES, 1, ack-low cycles after each ack before a new request is sampled; legal 1..3.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs_i  in  1  request select; level-sensitive, may stay high across a burst.
- we_i  in  1  1 = write, 0 = read; sampled with cs_i.
- addr_i  in  32  byte address; word index = addr_i[ADDR_WIDTH+1:2]; bits [1:0] and upper bits ignored (aliasing).
- data_i  in  32  write data; sampled at acceptance.
- data_o  out  32  read data; registered and held until the next read ack.
- ack_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async): state=IDLE, ack_o=0, data_o=0, latency counter=0, request latches=0. Array contents are not cleared. Reset mid-transaction drops the request: no write, no ack.
- States: IDLE, WAIT, ACK, REL.
- IDLE:
  - cs_i=1: latch word index, we_i and data_i; counter=LATENCY-1.
  - Next state is WAIT, or ACK directly if LATENCY=1.
  - cs_i=0: stay in IDLE.
- WAIT:
  - cs_i=0 at any cycle: abort to IDLE; no array write, no ack.
  - Otherwise decrement counter; go to ACK when counter==1.
  - Latency is therefore exactly LATENCY cycles from the accepting edge to ack_o high.
- ACK:
  - ack_o=1 for exactly one cycle.
  - Write: array[idx] <= latched data on this edge.
  - Read: data_o <= array[idx], registered so it is valid in the same cycle ack_o is high.
  - Writes do not alter data_o.
  - cs_i is ignored in ACK; the access commits. Next state is REL.
- REL:
  - ack_o=0 for REL_CYCLES cycles, then IDLE.
  - Guarantees an ack-low gap, and gives the requester time to advance the address before re-sampling.
- Changes to addr_i, we_i or data_i after acceptance have no effect on the in-flight request.
- Back-to-back burst: with cs_i held high, the words of a burst are spaced LATENCY+1+REL_CYCLES cycles apart (the extra 1 is the IDLE re-sampling cycle).
- Address wrap: index ADDR_WIDTH bits wide; 0x0000_1000 aliases 0x0 when ADDR_WIDTH=10.
- ack_o and data_o are purely registered; no combinational path from inputs.

Optional Feature:
- Macro MEM_STATS_EN.
- Defined:
  - Adds outputs rd_cnt_o[15:0] and wr_cnt_o[15:0].
  - Each increments on every committed read/write ack; aborted requests are not counted.
  - Both wrap at 16'hFFFF→0 and reset to 0 on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_define holds:
  - state encoding S_M_IDLE, S_M_WAIT, S_M_ACK, S_M_REL (2 bits);
  - word-offset constant 2;
  - latency counter width 4.
- Sub-module mem_array: single-port synchronous RAM with write enable and registered read, parameterized by ADDR_WIDTH.
- FSM and counters stay in mem_slave.

Test Plan (LATENCY=4 and REL_CYCLES=1 unless stated):
- Write then read: write 0xDEADBEEF to 0x40, then read 0x40 → ack_o high 4 cycles after each acceptance; data_o=0xDEADBEEF during the read ack.
- Burst of 4 reads, cs_i held high, address stepped 0x100→0x10C after each ack → four single-cycle acks spaced 6 cycles apart, ack low between them; data_o matches preloaded words 0x11,0x22,0x33,0x44.
- Abort: cs_i dropped 2 cycles into a write of 0x5555_5555 to 0x80 → no ack; a later read of 0x80 returns its prior value 0x0.
- Reset mid-WAIT: assert rst asynchronously (between clock edges) while in WAIT → ack_o=0 and data_o=0 immediately; state IDLE after release; no write occurred.
- LATENCY=1 with aliasing (ADDR_WIDTH=10): write 0xA5 to 0x1004, read 0x4 → ack 1 cycle after acceptance; data_o=0xA5.
- MEM_STATS_EN defined: 3 writes, 2 reads, 1 aborted read → wr_cnt_o=3, rd_cnt_o=2.
